// File: rtl/apbDecode_package.sv
// Shared APB types for the decode fabric, plus the initiator's state,
// response record and timeout read-data marker.
package apbDecode_package;

  typedef logic [31:0] apbAddrSt;
  typedef logic [31:0] apbDataSt;

  typedef enum logic [1:0] {
    INIT_IDLE   = 2'd0,
    INIT_SETUP  = 2'd1,
    INIT_ACCESS = 2'd2,
    INIT_RESP   = 2'd3
  } apbInitStateE;

  typedef struct packed {
    apbDataSt rdata;
    logic     err;
    logic     timeout;
  } apbInitRspSt;

  localparam apbDataSt APB_INIT_TIMEOUT_DATA = 32'hDEAD_0001;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle. src = initiator view, dst = completer view.
interface apb_if;
  import apbDecode_package::*;

  logic     psel;
  logic     penable;
  logic     pwrite;
  apbAddrSt paddr;
  apbDataSt pwdata;
  apbDataSt prdata;
  logic     pready;
  logic     pslverr;

  modport src (output psel, penable, pwrite, paddr, pwdata,
               input  prdata, pready, pslverr);
  modport dst (input  psel, penable, pwrite, paddr, pwdata,
               output prdata, pready, pslverr);
endinterface

// File: rtl/apb_initiator.sv
// APB initiator: one command in, one APB transfer out, one response back.
//   clk/rst      : clock, synchronous active-high reset
//   apbReg       : APB bus (initiator side)
//   cmd_*        : valid/ready command stream (write flag, byte address, data)
//   rsp_*        : valid/ready response stream (rdata, err, timeout)
//   err_count    : saturating count of error responses
// All outputs are registered; cmd_ready depends only on state.
module apb_initiator
  import apbDecode_package::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ERR_CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  apb_if.src                   apbReg,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  apbAddrSt             cmd_addr,
  input  apbDataSt             cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output apbDataSt             rsp_rdata,
  output logic                 rsp_err,
  output logic                 rsp_timeout,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  apbInitStateE  state;
  apbInitRspSt   rsp_q;
  logic [CW-1:0] wait_cnt;
  logic          to_hit;
  logic          err_sat;

  assign to_hit      = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);
  assign err_sat     = &err_count;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= INIT_IDLE;
      cmd_ready      <= 1'b0;
      apbReg.psel    <= 1'b0;
      apbReg.penable <= 1'b0;
      apbReg.pwrite  <= 1'b0;
      apbReg.paddr   <= '0;
      apbReg.pwdata  <= '0;
      rsp_valid      <= 1'b0;
      rsp_q          <= '0;
      err_count      <= '0;
      wait_cnt       <= '0;
    end else begin
      case (state)
        INIT_IDLE: begin
          // cmd_ready is itself registered, so it gates acceptance: the
          // first cycle after reset is not an accepting cycle.
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_addr[1:0] == 2'b00) begin
              state         <= INIT_SETUP;
              apbReg.psel   <= 1'b1;
              apbReg.pwrite <= cmd_write;
              apbReg.paddr  <= cmd_addr;
              apbReg.pwdata <= cmd_wdata;
            end else begin
              state     <= INIT_RESP;
              rsp_valid <= 1'b1;
              rsp_q     <= '{rdata: '0, err: 1'b1, timeout: 1'b0};
              if (!err_sat) err_count <= err_count + 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        INIT_SETUP: begin
          state          <= INIT_ACCESS;
          apbReg.penable <= 1'b1;
          wait_cnt       <= '0;
        end

        INIT_ACCESS: begin
          if (apbReg.pready) begin
            state          <= INIT_RESP;
            apbReg.psel    <= 1'b0;
            apbReg.penable <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_q.rdata    <= apbReg.pwrite ? '0 : apbReg.prdata;
            rsp_q.err      <= apbReg.pslverr;
            rsp_q.timeout  <= 1'b0;
            if (apbReg.pslverr && !err_sat) err_count <= err_count + 1'b1;
          end else if (to_hit) begin
            state          <= INIT_RESP;
            apbReg.psel    <= 1'b0;
            apbReg.penable <= 1'b0;
            rsp_valid      <= 1'b1;
            rsp_q          <= '{rdata: APB_INIT_TIMEOUT_DATA, err: 1'b1, timeout: 1'b1};
            if (!err_sat) err_count <= err_count + 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        INIT_RESP: begin
          if (rsp_ready) begin
            state     <= INIT_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: state <= INIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
module tb_apb_initiator;
  import apbDecode_package::*;

  localparam int unsigned TO_N = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
    int          lat;
    int          pen;
    int          psel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  apbAddrSt    cmd_addr = '0;
  apbDataSt    cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  apbDataSt    rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] err_count;

  // completer model: 0 = zero wait, 1 = one wait state, 2 = never ready
  logic [1:0]  mode = 2'd0;
  logic        force_rdy = 1'b0;
  logic        wait_done = 1'b0;
  logic [31:0] rd_val = '0;
  logic        err_val = 1'b0;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_errs = 0;
  exp_t sb[$];

  apb_if bus ();

  apb_initiator #(.TIMEOUT_CYCLES(TO_N), .ERR_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .apbReg(bus),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.psel && bus.penable && !wait_done) wait_done <= 1'b1;
    else if (!bus.penable) wait_done <= 1'b0;
  end

  assign bus.pready  = (mode == 2'd0) ? 1'b1 : (mode == 2'd1) ? wait_done : force_rdy;
  assign bus.prdata  = rd_val;
  assign bus.pslverr = err_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Issue one command, watch the bus, compare the response against the
  // scoreboard entry pushed at issue time.
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] e_rdata, input logic e_err, input logic e_to,
                        input int e_lat, input int e_pen, input int e_psel);
    exp_t e;
    exp_t g;
    int n;
    int acc;
    int psel_n;
    int pen_n;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    check("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    e = '{rdata: e_rdata, err: e_err, timeout: e_to, lat: e_lat, pen: e_pen, psel: e_psel};
    sb.push_back(e);
    if (e_err) exp_errs++;
    @(negedge clk);
    acc = cyc;
    cmd_valid = 1'b0;
    psel_n = 0; pen_n = 0; n = 0;
    while (!rsp_valid && n < 40) begin
      if (bus.psel) begin
        psel_n++;
        check("pwrite", {31'd0, bus.pwrite}, {31'd0, wr});
        check("paddr", bus.paddr, addr);
        if (wr) check("pwdata", bus.pwdata, wd);
      end
      if (bus.penable) pen_n++;
      @(negedge clk); n++;
    end
    check("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    g = sb.pop_front();
    check("latency", cyc - acc + 1, g.lat);
    check("penable_cycles", pen_n, g.pen);
    check("psel_cycles", psel_n, g.psel);
    check("rsp_rdata", rsp_rdata, g.rdata);
    check("rsp_err", {31'd0, rsp_err}, {31'd0, g.err});
    check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, g.timeout});
    check("err_count", {16'd0, err_count}, exp_errs);
    check("cmd_ready_in_resp", {31'd0, cmd_ready}, 32'd0);
  endtask

  initial begin
    int bad;
    int n;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_psel", {31'd0, bus.psel}, 32'd0);
    check("rst_penable", {31'd0, bus.penable}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_err_count", {16'd0, err_count}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // 1: zero-wait write
    mode = 2'd0; rd_val = 32'hFFFF_FFFF; err_val = 1'b0;
    do_cmd(1'b1, 32'h208, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 3, 1, 2);

    // 2: one-wait read
    @(negedge clk);
    mode = 2'd1; rd_val = 32'h0000_0015;
    do_cmd(1'b0, 32'h200, 32'h0, 32'h15, 1'b0, 1'b0, 4, 2, 3);

    // 3: slave error
    @(negedge clk);
    mode = 2'd0; rd_val = 32'hBADD_C0DE; err_val = 1'b1;
    do_cmd(1'b0, 32'h300, 32'h0, 32'hBADD_C0DE, 1'b1, 1'b0, 3, 1, 2);
    err_val = 1'b0;

    // 4: misaligned, no bus cycle
    @(negedge clk);
    do_cmd(1'b1, 32'h206, 32'hAAAA_5555, 32'h0, 1'b1, 1'b0, 1, 0, 0);

    // 5: timeout, then a late pready must be ignored
    @(negedge clk);
    mode = 2'd2; force_rdy = 1'b0; rd_val = 32'h1111_2222;
    do_cmd(1'b0, 32'h100, 32'h0, APB_INIT_TIMEOUT_DATA, 1'b1, 1'b1, 2 + TO_N, TO_N, TO_N + 1);
    @(negedge clk);
    force_rdy = 1'b1;
    bad = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (i == 2) force_rdy = 1'b0;
      if (rsp_valid || bus.psel) bad++;
      @(negedge clk);
    end
    check("late_pready_ignored", bad, 0);

    // 6: backpressure holds the response, then reset mid-ACCESS
    mode = 2'd0; rd_val = 32'h0000_A5A5; rsp_ready = 1'b0;
    do_cmd(1'b0, 32'h204, 32'h0, 32'hA5A5, 1'b0, 1'b0, 3, 1, 2);
    rd_val = 32'h5555_0000;
    bad = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== 32'hA5A5 || rsp_err || rsp_timeout || cmd_ready) bad++;
    end
    check("held_response", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_released", {31'd0, rsp_valid}, 32'd0);

    mode = 2'd2;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h104;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("in_access_before_rst", {31'd0, bus.penable}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_psel", {31'd0, bus.psel}, 32'd0);
    check("rst_mid_penable", {31'd0, bus.penable}, 32'd0);
    check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_err_count", {16'd0, err_count}, 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || bus.psel) bad++;
    end
    check("no_rsp_after_rst", bad, 0);
    check("idle_after_rst", {31'd0, cmd_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
